// File: rtl/user_data_mem.sv
// User data memory: a small register-file image with two combinational read
// ports, one write port and a sequenced reload that restores the INIT image
// one word per clock. Reset restores the whole image at once.
module user_data_mem #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  parameter logic [WIDTH*DEPTH-1:0] INIT =
    ((WIDTH*DEPTH)'(3) << WIDTH) | (WIDTH*DEPTH)'(7),
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             reload,
  output logic             busy,
  output logic             done,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  output logic             wr_drop,
  input  logic [AW-1:0]    rd_addr_a,
  input  logic [AW-1:0]    rd_addr_b,
  output logic [WIDTH-1:0] rd_data_a,
  output logic [WIDTH-1:0] rd_data_b
);

  // state | meaning
  // IDLE  | user writes accepted, reload request starts a load
  // LOAD  | one INIT word copied per clock, pointer walks 0..DEPTH-1
  // DONE  | single-cycle completion flag, then back to IDLE
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic [AW-1:0] PTR_LAST = AW'(DEPTH - 1);

  state_e           state_q, state_d;
  logic [AW-1:0]    ptr_q, ptr_d;
  logic             wr_drop_q, wr_drop_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];

  logic wr_ok;
  logic rd_ok_a;
  logic rd_ok_b;

  // Address range qualification; AW can cover more than DEPTH words.
  always_comb begin
    wr_ok   = int'(wr_addr) < DEPTH;
    rd_ok_a = int'(rd_addr_a) < DEPTH;
    rd_ok_b = int'(rd_addr_b) < DEPTH;
  end

  // Zero-latency read ports; out-of-range addresses read as zero.
  always_comb begin
    rd_data_a = '0;
    rd_data_b = '0;
    if (rd_ok_a) begin
      rd_data_a = mem_q[rd_addr_a];
    end
    if (rd_ok_b) begin
      rd_data_b = mem_q[rd_addr_b];
    end
  end

  // Next-state, pointer, memory update and write-drop decision.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    mem_d     = mem_q;
    wr_drop_d = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        // The user write lands first; a simultaneous reload overwrites it later.
        if (wr_en) begin
          if (wr_ok) begin
            mem_d[wr_addr] = wr_data;
          end else begin
            wr_drop_d = 1'b1;
          end
        end
        if (reload) begin
          state_d = ST_LOAD;
          ptr_d   = '0;
        end
      end
      ST_LOAD: begin
        mem_d[ptr_q] = INIT[int'(ptr_q)*WIDTH +: WIDTH];
        wr_drop_d    = wr_en;
        // Pointer parks on the last word rather than wrapping.
        if (ptr_q == PTR_LAST) begin
          state_d = ST_DONE;
        end else begin
          ptr_d = ptr_q + AW'(1);
        end
      end
      ST_DONE: begin
        wr_drop_d = wr_en;
        state_d   = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State registers; reset restores the full INIT image without a clock.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      ptr_q     <= '0;
      wr_drop_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= INIT[i*WIDTH +: WIDTH];
      end
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      wr_drop_q <= wr_drop_d;
      mem_q     <= mem_d;
    end
  end

  assign busy    = (state_q == ST_LOAD);
  assign done    = (state_q == ST_DONE);
  assign wr_drop = wr_drop_q;

endmodule
